hps_pll_lock_supervisor: RTL and testbench

Lock supervisor that sits on the other side of the HPS memory PLL wrapper's reset/locked interface. It drives the PLL reset input and consumes the PLL `locked` output, all in the `refclk` domain. It pulses the PLL reset, waits for lock with a timeout and bounded retries, and qualifies lock as stable. Only then does it release a downstream system reset and assert `ready`. On loss of lock it re-asserts the downstream reset and re-runs the sequence.

---
 rtl/hps_pll_lock_supervisor.sv | 179 +++++++++++++++++
 tb/tb_hps_pll_lock_supervisor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_pll_lock_supervisor.sv
// hps_pll_lock_supervisor
//
// Brings the HPS memory PLL out of reset and holds the downstream system in
// reset until the PLL has reported a stable lock. The PLL reset is pulsed and
// then lock is awaited with a timeout. A bounded number of retries is allowed
// before the block parks in a failed state. Lock must then stay up for a
// qualification window. Losing lock while running re-asserts the downstream
// reset and restarts the whole sequence. Everything runs on refclk.
//
// Ports:
//   refclk       in   sole clock
//   rst          in   synchronous, active-high reset
//   locked_in    in   PLL locked, asynchronous to refclk
//   retry_req    in   single-cycle request to leave FAILED
//   pll_rst      out  PLL reset (registered)
//   sys_rst      out  downstream reset, active-high (registered)
//   ready        out  lock qualified, equal to ~sys_rst & ~fail (registered)
//   fail         out  retries exhausted (registered)
//   retry_count  out  lock timeouts since the last RUNNING entry or retry_req
//   loss_count   out  lock losses seen while RUNNING, saturating at 255

module hps_pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked_in,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] retry_count,
    output logic [7:0] loss_count
);

    // The single shared counter must hold the largest terminal count of the
    // three timed phases.
    localparam int MAX_AB     = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > LOCK_STABLE_CYCLES) ?
                                MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RUNNING,
        ST_FAILED
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             retryCount_q, retryCount_d;
    logic [7:0]             lossCount_q, lossCount_d;
    logic [SYNC_STAGES-1:0] lockSync_q;
    logic                   lockedS;
    logic                   pllRst_q, sysRst_q, ready_q, fail_q;

    // locked_in comes straight from the PLL with no relation to refclk, so it
    // is passed through a plain flop chain before anything looks at it. Only
    // the last stage is ever used by the sequencer.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lockSync_q <= '0;
        end else begin
            lockSync_q <= {lockSync_q[SYNC_STAGES-2:0], locked_in};
        end
    end

    assign lockedS = lockSync_q[SYNC_STAGES-1];

    // Next-state decode. In STABILIZE and RUNNING a lock drop is tested
    // before the counter terminal count, so a drop always wins a tie. The
    // shared counter only runs in the three timed states and is cleared
    // whenever the state changes, so each phase starts counting from zero.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retryCount_d = retryCount_q;
        lossCount_d  = lossCount_q;

        case (state_q)
            ST_PLL_RESET: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                cnt_d = cnt_q + CNT_ONE;
                if (lockedS) begin
                    state_d = ST_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retryCount_q == RETRY_LIMIT) begin
                        state_d = ST_FAILED;
                    end else begin
                        retryCount_d = retryCount_q + 8'd1;
                        state_d      = ST_PLL_RESET;
                    end
                end
            end
            ST_STABILIZE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (!lockedS) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    retryCount_d = 8'd0;
                    state_d      = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (!lockedS) begin
                    if (lossCount_q != 8'hFF) begin
                        lossCount_d = lossCount_q + 8'd1;
                    end
                    state_d = ST_PLL_RESET;
                end
            end
            ST_FAILED: begin
                if (retry_req) begin
                    retryCount_d = 8'd0;
                    state_d      = ST_PLL_RESET;
                end
            end
            default: begin
                state_d = ST_PLL_RESET;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // State, counters and outputs share one register stage. The outputs are
    // decoded from the next state, so they change on the same edge as the
    // state register and never see a combinational path from any input.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= ST_PLL_RESET;
            cnt_q        <= '0;
            retryCount_q <= 8'd0;
            lossCount_q  <= 8'd0;
            pllRst_q     <= 1'b1;
            sysRst_q     <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retryCount_q <= retryCount_d;
            lossCount_q  <= lossCount_d;
            pllRst_q     <= (state_d == ST_PLL_RESET) || (state_d == ST_FAILED);
            sysRst_q     <= (state_d != ST_RUNNING);
            ready_q      <= (state_d == ST_RUNNING);
            fail_q       <= (state_d == ST_FAILED);
        end
    end

    assign pll_rst     = pllRst_q;
    assign sys_rst     = sysRst_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retryCount_q;
    assign loss_count  = lossCount_q;

endmodule

// File: tb/tb_hps_pll_lock_supervisor.sv
// tb_hps_pll_lock_supervisor
//
// Directed-sequence bench for the PLL lock supervisor with randomized event
// timing. Expected outputs for every checked cycle are worked out from the
// sequencing rules with plain arithmetic on cycle offsets: pulse width,
// synchronizer delay, qualification window and timeout period.
// Cycle 0 of a scenario is the first cycle in which the supervisor is
// sequencing on its own. That is either the cycle after reset is released or
// the cycle after the accepted retry request.

module tb_hps_pll_lock_supervisor;

    localparam int RST_PULSE = 4;
    localparam int TIMEOUT   = 32;
    localparam int STABLE    = 8;
    localparam int MAX_RETRY = 2;
    localparam int SYNC      = 2;
    localparam int PERIOD    = RST_PULSE + TIMEOUT;
    localparam int FAIL_AT   = (MAX_RETRY + 1) * PERIOD;

    localparam logic [19:0] RESET_EXP = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};

    logic       refclk;
    logic       rst;
    logic       locked_in;
    logic       retry_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [7:0] retry_count;
    logic [7:0] loss_count;

    int compared;
    int mismatched;
    int cycleNum;

    hps_pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (RST_PULSE),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .LOCK_STABLE_CYCLES  (STABLE),
        .MAX_RETRIES         (MAX_RETRY),
        .SYNC_STAGES         (SYNC)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked_in   (locked_in),
        .retry_req   (retry_req),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count),
        .loss_count  (loss_count)
    );

    // 10-unit free-running reference clock.
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Output bundle ordering used by every comparison:
    // {pll_rst, sys_rst, ready, fail, retry_count, loss_count}.
    function automatic logic [19:0] packExp(input logic pll, input logic sys,
                                            input logic rdy, input logic fl,
                                            input int rc, input int lc);
        return {pll, sys, rdy, fl, rc[7:0], lc[7:0]};
    endfunction

    // Clean bring-up from the start of a PLL reset pulse with lock arriving
    // at cycle lockAt. The lock needs SYNC cycles to reach the sequencer. It
    // takes one more cycle to enter STABILIZE and STABLE further cycles to
    // qualify.
    function automatic logic [19:0] bringUpExp(input int c, input int lockAt,
                                               input int lc);
        int  readyAt;
        logic rdy;
        readyAt = lockAt + SYNC + 1 + STABLE;
        rdy     = (c >= readyAt);
        return packExp(c < RST_PULSE, !rdy, 1'(rdy), 1'b0, 0, lc);
    endfunction

    // Lock never arrives: each attempt is one reset pulse plus one timeout
    // window. After MAX_RETRY retries, the next timeout parks the block in
    // FAILED.
    function automatic logic [19:0] timeoutExp(input int c);
        if (c >= FAIL_AT) begin
            return packExp(1'b1, 1'b1, 1'b0, 1'b1, MAX_RETRY, 0);
        end
        return packExp((c % PERIOD) < RST_PULSE, 1'b1, 1'b0, 1'b0, c / PERIOD, 0);
    endfunction

    // Advance to just after the next rising edge, where new inputs are driven.
    task automatic tick();
        @(posedge refclk);
        #1;
        cycleNum++;
    endtask

    // Drive the sequencer inputs for the current cycle.
    task automatic applyStimulus(input logic lk, input logic rq);
        locked_in = lk;
        retry_req = rq;
    endtask

    // Sample the outputs on the falling edge of the current cycle and compare.
    task automatic checkOutput(input string tag, input logic [19:0] expected);
        logic [19:0] observed;
        @(negedge refclk);
        observed = {pll_rst, sys_rst, ready, fail, retry_count, loss_count};
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s cycle %0d: observed %h expected %h {pll,sys,rdy,fail,retry,loss}",
                   tag, cycleNum, observed, expected);
        end
    endtask

    // Hold reset across two edges, then release it. The cycle right after
    // release becomes cycle 0 and still shows reset values.
    task automatic resetDut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cycleNum = 0;
    endtask

    // Main directed sequence.
    initial begin
        int lockAt;
        int relockAt;
        int readyAt;
        int stabAt;
        int glitchAt;
        int holdCycles;
        int retryAt;
        int resetAt;
        int sat;
        logic rdy;
        logic lk;

        compared   = 0;
        mismatched = 0;
        cycleNum   = 0;
        rst        = 1'b1;
        locked_in  = 1'b0;
        retry_req  = 1'b0;

        repeat (3) tick();
        checkOutput("reset_state", RESET_EXP);

        // Normal bring-up with lock arriving at cycle 10.
        resetDut();
        for (int c = 0; c <= 10 + SYNC + 1 + STABLE + 2; c++) begin
            applyStimulus(c >= 10, 1'b0);
            checkOutput("bringup", bringUpExp(c, 10, 0));
            tick();
        end

        // A retry request while RUNNING must be ignored.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, k == 1);
            checkOutput("retry_req_running", packExp(1'b0, 1'b0, 1'b1, 1'b0, 0, 0));
            tick();
        end

        // Lock loss while RUNNING with a random relock delay. The
        // downstream reset returns SYNC+1 cycles after the drop, followed by
        // a full new reset pulse.
        relockAt = int'($urandom_range(1, 12));
        stabAt   = ((relockAt + SYNC) > (SYNC + 1 + RST_PULSE)) ?
                   (relockAt + SYNC + 1) : (SYNC + 1 + RST_PULSE + 1);
        readyAt  = stabAt + STABLE;
        for (int k = 0; k <= readyAt + 1; k++) begin
            applyStimulus(k >= relockAt, 1'b0);
            rdy = (k < SYNC + 1) || (k >= readyAt);
            checkOutput("loss_running",
                        packExp((k >= SYNC + 1) && (k < SYNC + 1 + RST_PULSE),
                                !rdy, rdy, 1'b0, 0, (k >= SYNC + 1) ? 1 : 0));
            tick();
        end

        // Repeated one-cycle drops push the loss counter into saturation.
        // Each drop re-qualifies on a fixed schedule: back in RUNNING 16
        // cycles after the drop.
        for (int n = 2; n <= 300; n++) begin
            sat = (n > 255) ? 255 : n;
            applyStimulus(1'b0, 1'b0);
            tick();
            applyStimulus(1'b1, 1'b0);
            repeat (14) tick();
            checkOutput("loss_relock_pending", packExp(1'b0, 1'b1, 1'b0, 1'b0, 0, sat));
            tick();
            checkOutput("loss_relock_ready", packExp(1'b0, 1'b0, 1'b1, 1'b0, 0, sat));
            tick();
        end

        // Reset while RUNNING with a saturated loss counter.
        rst = 1'b1;
        tick();
        checkOutput("reset_in_running", RESET_EXP);

        // No lock at all. Timeouts lead to FAILED, with stray retry requests
        // in WAIT_LOCK and PLL_RESET along the way. The accepted retry
        // request then restarts the sequence.
        resetDut();
        holdCycles = int'($urandom_range(3, 15));
        retryAt    = FAIL_AT + holdCycles;
        for (int c = 0; c <= retryAt; c++) begin
            applyStimulus(1'b0, (c == 20) || (c == PERIOD + 1) || (c == 50) || (c == retryAt));
            checkOutput("timeout_seq", timeoutExp(c));
            tick();
        end
        lockAt = int'($urandom_range(4, 20));
        for (int j = 0; j <= lockAt + SYNC + 1 + STABLE + 1; j++) begin
            applyStimulus(j >= lockAt, 1'b0);
            checkOutput("retry_restart", bringUpExp(j, lockAt, 0));
            tick();
        end

        // Lock glitch of three cycles during STABILIZE. Qualification must
        // restart from the relock with no retry counted.
        resetDut();
        lockAt   = int'($urandom_range(5, 15));
        glitchAt = lockAt + int'($urandom_range(1, 8));
        for (int c = 0; c <= glitchAt + 3 + SYNC + 1 + STABLE + 1; c++) begin
            lk = (c >= lockAt) && !((c >= glitchAt) && (c < glitchAt + 3));
            applyStimulus(lk, 1'b0);
            checkOutput("stabilize_glitch", bringUpExp(c, glitchAt + 3, 0));
            tick();
        end

        // One timeout, then lock in the second attempt, then reset in the
        // middle of STABILIZE while retry_count is 1.
        resetDut();
        stabAt  = PERIOD + RST_PULSE + SYNC + 1;
        resetAt = stabAt + int'($urandom_range(0, STABLE - 2));
        for (int c = 0; c <= resetAt; c++) begin
            applyStimulus(c >= PERIOD + RST_PULSE, 1'b0);
            if (c < stabAt) begin
                checkOutput("stabilize_pre_reset", timeoutExp(c));
            end else begin
                checkOutput("stabilize_pre_reset", packExp(1'b0, 1'b1, 1'b0, 1'b0, 1, 0));
            end
            if (c == resetAt) begin
                rst = 1'b1;
            end
            tick();
        end
        checkOutput("reset_in_stabilize", RESET_EXP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
